// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the MIPS-32 core: owns the PC, handshakes with
// instruction memory and selects the next PC from branch, jump and JR targets.
module pc_sequencer #(
    parameter int unsigned           WIDTH_PC     = 32,
    parameter logic [WIDTH_PC-1:0]   RESET_VECTOR = '0,
    parameter int unsigned           CNT_W        = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    output logic                o_imem_req,
    input  logic                i_imem_ack,
    input  logic [31:0]         i_imem_rdata,
    output logic [WIDTH_PC-1:0] o_pc,
    output logic [31:0]         o_instr,
    output logic                o_instr_valid,
    input  logic                i_branch,
    input  logic                i_zero,
    input  logic                i_jump_sel,
    input  logic                i_jr_sel,
    input  logic [WIDTH_PC-1:0] i_jr_addr,
    input  logic                i_halt,
    output logic [1:0]          o_pc_src,
    output logic                o_halted,
    output logic                o_misalign,
    output logic [CNT_W-1:0]    o_redirect_cnt
);

    localparam int unsigned SRC_W = 2;

    localparam logic [SRC_W-1:0] SRC_SEQ    = 2'd0;
    localparam logic [SRC_W-1:0] SRC_BRANCH = 2'd1;
    localparam logic [SRC_W-1:0] SRC_JUMP   = 2'd2;
    localparam logic [SRC_W-1:0] SRC_JR     = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH_PC-1:0] pc_nxt;
    logic [WIDTH_PC-1:0] pc4;
    logic [WIDTH_PC-1:0] br_target;
    logic [WIDTH_PC-1:0] j_target;
    logic [WIDTH_PC-1:0] jr_target;

    // Candidate targets, all wrapping modulo 2^WIDTH_PC
    always_comb begin
        pc4       = o_pc + WIDTH_PC'(4);
        br_target = pc4 + {{(WIDTH_PC-18){o_instr[15]}}, o_instr[15:0], 2'b00};
        j_target  = {pc4[WIDTH_PC-1:28], o_instr[25:0], 2'b00};
        jr_target = {i_jr_addr[WIDTH_PC-1:2], 2'b00};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next-PC selection; priority halt > JR > jump > taken branch
    always_comb begin
        state_nxt = state;
        o_pc_src  = SRC_SEQ;
        pc_nxt    = o_pc;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (i_imem_ack) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (i_halt) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = FETCH;
                    if (i_jr_sel) begin
                        o_pc_src = SRC_JR;
                        pc_nxt   = jr_target;
                    end else if (i_jump_sel) begin
                        o_pc_src = SRC_JUMP;
                        pc_nxt   = j_target;
                    end else if (i_branch && i_zero) begin
                        o_pc_src = SRC_BRANCH;
                        pc_nxt   = br_target;
                    end else begin
                        pc_nxt   = pc4;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers; status outputs are registered from the next state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_pc           <= RESET_VECTOR;
            o_instr        <= '0;
            o_imem_req     <= 1'b0;
            o_instr_valid  <= 1'b0;
            o_halted       <= 1'b0;
            o_misalign     <= 1'b0;
            o_redirect_cnt <= '0;
        end else begin
            o_pc          <= pc_nxt;
            o_imem_req    <= (state_nxt == FETCH);
            o_instr_valid <= (state_nxt == EXEC);
            o_halted      <= (state_nxt == HALT);
            if (state == FETCH && i_imem_ack) begin
                o_instr <= i_imem_rdata;
            end
            if (o_pc_src == SRC_JR && i_jr_addr[1:0] != 2'b00) begin
                o_misalign <= 1'b1;
            end
            if (o_pc_src != SRC_SEQ && o_redirect_cnt != {CNT_W{1'b1}}) begin
                o_redirect_cnt <= o_redirect_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table of fetch/execute steps
// with a scoreboard for the executed instruction, plus reset/halt corner cases.
module tb_pc_sequencer;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic        o_imem_req;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        i_branch;
    logic        i_zero;
    logic        i_jump_sel;
    logic        i_jr_sel;
    logic [31:0] i_jr_addr;
    logic        i_halt;
    logic [1:0]  o_pc_src;
    logic        o_halted;
    logic        o_misalign;
    logic [15:0] o_redirect_cnt;

    pc_sequencer #(
        .WIDTH_PC     (32),
        .RESET_VECTOR (32'h0000_0000),
        .CNT_W        (16)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .o_imem_req     (o_imem_req),
        .i_imem_ack     (i_imem_ack),
        .i_imem_rdata   (i_imem_rdata),
        .o_pc           (o_pc),
        .o_instr        (o_instr),
        .o_instr_valid  (o_instr_valid),
        .i_branch       (i_branch),
        .i_zero         (i_zero),
        .i_jump_sel     (i_jump_sel),
        .i_jr_sel       (i_jr_sel),
        .i_jr_addr      (i_jr_addr),
        .i_halt         (i_halt),
        .o_pc_src       (o_pc_src),
        .o_halted       (o_halted),
        .o_misalign     (o_misalign),
        .o_redirect_cnt (o_redirect_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        logic        br;
        logic        zero;
        logic        jmp;
        logic        jr;
        logic [31:0] jr_addr;
        logic        halt;
        int          ack_delay;
        logic [1:0]  src;
        logic [31:0] pc;
        logic [15:0] cnt;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  src;
    } sb_t;

    sb_t   sb[$];
    vec_t  tbl[14];
    int    errors = 0;
    int    checks = 0;
    logic [31:0] cur_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_pc",    o_pc, 32'h0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_req",   32'(o_imem_req), 32'h0);
        check("rst_valid", 32'(o_instr_valid), 32'h0);
        check("rst_src",   32'(o_pc_src), 32'h0);
        check("rst_halt",  32'(o_halted), 32'h0);
        check("rst_mis",   32'(o_misalign), 32'h0);
        check("rst_cnt",   32'(o_redirect_cnt), 32'h0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        @(posedge i_clk); #2;
        check_reset_state();
        i_rst_n = 1'b1;
        cur_pc  = 32'h0;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (o_imem_req !== 1'b1 && n < 20) begin
            @(posedge i_clk); #2;
            n++;
        end
        check("req_wait", 32'(o_imem_req), 32'h1);
    endtask

    // One fetch/execute round: optional ack stall, then EXEC with the vector's controls
    task automatic do_instr(input vec_t v);
        sb_t e;
        wait_req();
        for (int d = 0; d < v.ack_delay; d++) begin
            check("stall_req",   32'(o_imem_req), 32'h1);
            check("stall_pc",    o_pc, cur_pc);
            check("stall_valid", 32'(o_instr_valid), 32'h0);
            @(posedge i_clk); #2;
        end
        check("fetch_pc", o_pc, cur_pc);
        i_imem_ack   = 1'b1;
        i_imem_rdata = v.instr;
        sb.push_back('{v.instr, v.src});
        @(posedge i_clk); #1;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'hDEAD_BEEF;
        i_branch     = v.br;
        i_zero       = v.zero;
        i_jump_sel   = v.jmp;
        i_jr_sel     = v.jr;
        i_jr_addr    = v.jr_addr;
        i_halt       = v.halt;
        #1;
        check("exec_valid", 32'(o_instr_valid), 32'h1);
        check("exec_req",   32'(o_imem_req), 32'h0);
        if (sb.size() == 0) begin
            check("sb_empty", 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            check("exec_instr", o_instr, e.instr);
            check("exec_src",   32'(o_pc_src), 32'(e.src));
        end
        @(posedge i_clk); #1;
        i_branch   = 1'b0;
        i_zero     = 1'b0;
        i_jump_sel = 1'b0;
        i_jr_sel   = 1'b0;
        i_jr_addr  = 32'h0;
        i_halt     = 1'b0;
        #1;
        check("next_pc",  o_pc, v.pc);
        check("cnt",      32'(o_redirect_cnt), 32'(v.cnt));
        check("misalign", 32'(o_misalign), 32'(v.mis));
        check("halted",   32'(o_halted), 32'(v.halt));
        cur_pc = v.pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            instr          br    z     jmp   jr    jr_addr        halt  dly src   pc             cnt    mis
        tbl[0]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'd0, 32'h0000_0004, 16'd0, 1'b0};
        tbl[1]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'd0, 32'h0000_0008, 16'd0, 1'b0};
        tbl[2]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'd0, 32'h0000_000C, 16'd0, 1'b0};
        tbl[3]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'd0, 32'h0000_0010, 16'd0, 1'b0};
        tbl[4]  = '{32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'd1, 32'h0000_0010, 16'd1, 1'b0};
        tbl[5]  = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'd0, 32'h0000_0014, 16'd1, 1'b0};
        tbl[6]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0008, 1'b0, 1, 2'd3, 32'h4000_0008, 16'd2, 1'b0};
        tbl[7]  = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 0, 2'd2, 32'h4000_0100, 16'd3, 1'b0};
        tbl[8]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1236, 1'b0, 0, 2'd3, 32'h0000_1234, 16'd4, 1'b1};
        tbl[9]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 5, 2'd0, 32'h0000_1238, 16'd4, 1'b1};
        tbl[10] = '{32'h1000_0003, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'd1, 32'h0000_1248, 16'd5, 1'b1};
        tbl[11] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 0, 2'd3, 32'hFFFF_FFFC, 16'd6, 1'b1};
        tbl[12] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0, 2'd0, 32'h0000_0000, 16'd6, 1'b1};
        tbl[13] = '{32'h0000_000D, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 2, 2'd0, 32'h0000_0000, 16'd6, 1'b1};

        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'h0;
        i_branch     = 1'b0;
        i_zero       = 1'b0;
        i_jump_sel   = 1'b0;
        i_jr_sel     = 1'b0;
        i_jr_addr    = 32'h0;
        i_halt       = 1'b0;
        cur_pc       = 32'h0;

        do_reset();
        check("idle_req", 32'(o_imem_req), 32'h0);
        do_start();
        for (int i = 0; i < 14; i++) begin
            do_instr(tbl[i]);
        end

        // HALT: start ignored, no fetch, ack and rdata ignored
        check("halt_src", 32'(o_pc_src), 32'h0);
        i_start = 1'b1;
        repeat (3) @(posedge i_clk);
        #2;
        check("halt_stay",  32'(o_halted), 32'h1);
        check("halt_req",   32'(o_imem_req), 32'h0);
        check("halt_pc",    o_pc, 32'h0);
        check("halt_valid", 32'(o_instr_valid), 32'h0);
        i_start      = 1'b0;
        i_imem_ack   = 1'b1;
        i_imem_rdata = 32'hCAFE_F00D;
        @(posedge i_clk); #2;
        check("halt_ack_ignored", o_instr, 32'h0000_000D);
        i_imem_ack   = 1'b0;

        // Reset out of HALT, jump to the top of memory, then reset mid-FETCH
        do_reset();
        do_start();
        v = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 0, 2'd3, 32'hFFFF_FFFC, 16'd1, 1'b0};
        do_instr(v);
        wait_req();
        check("pre_rst_pc", o_pc, 32'hFFFF_FFFC);
        i_rst_n = 1'b0;
        @(posedge i_clk); #2;
        check_reset_state();
        i_rst_n = 1'b1;
        cur_pc  = 32'h0;

        // Fresh run after mid-FETCH reset
        do_start();
        v = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1, 2'd0, 32'h0000_0004, 16'd0, 1'b0};
        do_instr(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
